viterbi_acs_sequencer: RTL and testbench

//   Sequences the Viterbi add-compare-select (ACS) datapath over all trellis states per received symbol.

---
 rtl/viterbi_acs_sequencer_if.sv | 50 +++++
 rtl/viterbi_acs_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_viterbi_acs_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/viterbi_acs_sequencer_if.sv
// ---------------------------------------------------------------------------
// viterbi_acs_sequencer_if
//   Bundles the data-path facing signals of the Viterbi ACS sequencer:
//   symbol FIFO handshake, ACS unit control, survivor-memory write port,
//   metric normalisation strobe and the traceback request/complete pair.
//
//   master : the sequencer (drives sym_ready, ACS/survivor/norm/traceback
//            controls; receives sym_valid, sym_last, acs_metric, tb_done)
//   slave  : the surrounding datapath / environment
//
//   Signals
//     sym_valid  / sym_last / sym_ready   symbol input handshake
//     acs_en / acs_idx / acs_metric       ACS unit control and returned metric
//     sv_we / sv_addr                     survivor memory write strobe and row
//     norm_en / norm_val                  metric normalisation strobe and amount
//     tb_start / tb_state / tb_len        traceback request
//     tb_done                             traceback completion
// ---------------------------------------------------------------------------
interface viterbi_acs_sequencer_if #(
   parameter int SW  = 4,
   parameter int MW  = 8,
   parameter int STW = 6
);
   logic           sym_valid;
   logic           sym_last;
   logic           sym_ready;
   logic           acs_en;
   logic [SW-1:0]  acs_idx;
   logic [MW-1:0]  acs_metric;
   logic           sv_we;
   logic [STW-1:0] sv_addr;
   logic           norm_en;
   logic [MW-1:0]  norm_val;
   logic           tb_start;
   logic [SW-1:0]  tb_state;
   logic [STW:0]   tb_len;
   logic           tb_done;

   modport master (
      input  sym_valid, sym_last, acs_metric, tb_done,
      output sym_ready, acs_en, acs_idx, sv_we, sv_addr,
             norm_en, norm_val, tb_start, tb_state, tb_len
   );

   modport slave (
      output sym_valid, sym_last, acs_metric, tb_done,
      input  sym_ready, acs_en, acs_idx, sv_we, sv_addr,
             norm_en, norm_val, tb_start, tb_state, tb_len
   );
endinterface

// File: rtl/viterbi_acs_sequencer.sv
// ---------------------------------------------------------------------------
// viterbi_acs_sequencer
//   Steps the Viterbi add-compare-select datapath over every trellis state for
//   each received symbol, writes one survivor decision per state, tracks the
//   minimum path metric (and the state holding it) for normalisation, and at
//   the end of a frame hands the best end state to the traceback unit.
//
//   Ports
//     i_clk     rising-edge clock
//     i_rst     synchronous active-high reset
//     i_start   begin a frame (only honoured when idle)
//     i_abort   cancel the frame from any state
//     o_busy    high whenever the sequencer is not idle
//     o_done    one-cycle pulse: frame completed after traceback
//     o_error   one-cycle pulse: MAX_STEPS symbols without a final marker
//     bus       viterbi_acs_sequencer_if.master (symbol, ACS, survivor,
//               normalisation and traceback signals)
//
//   Per symbol: 1 accept cycle + NUM_STATES ACS cycles + 1 normalise cycle.
// ---------------------------------------------------------------------------
module viterbi_acs_sequencer #(
   parameter int NUM_STATES = 11,
   parameter int SW         = 4,
   parameter int MW         = 8,
   parameter int MAX_STEPS  = 64,
   parameter int STW        = $clog2(MAX_STEPS)
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_start,
   input  logic i_abort,
   output logic o_busy,
   output logic o_done,
   output logic o_error,
   viterbi_acs_sequencer_if.master bus
);

   localparam logic [SW-1:0] LAST_IDX   = SW'(NUM_STATES - 1);
   localparam logic [STW:0]  STEP_LIMIT = (STW + 1)'(MAX_STEPS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_SYM,
      S_ACS,
      S_NORM,
      S_TB_REQ,
      S_TB_WAIT
   } state_t;

   state_t          r_state;
   logic [SW-1:0]   r_idx;
   logic [STW:0]    r_step;      // one bit wider than sv_addr so a full frame length fits
   logic [MW-1:0]   r_min;
   logic [SW-1:0]   r_argmin;
   logic            r_last;
   logic            r_done;
   logic            r_error;

   state_t          w_state_next;
   logic [SW-1:0]   w_idx_next;
   logic [STW:0]    w_step_next;
   logic [MW-1:0]   w_min_next;
   logic [SW-1:0]   w_argmin_next;
   logic            w_last_next;
   logic            w_done_next;
   logic            w_error_next;

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_idx    <= '0;
         r_step   <= '0;
         r_min    <= '1;
         r_argmin <= '0;
         r_last   <= 1'b0;
         r_done   <= 1'b0;
         r_error  <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_idx    <= w_idx_next;
         r_step   <= w_step_next;
         r_min    <= w_min_next;
         r_argmin <= w_argmin_next;
         r_last   <= w_last_next;
         r_done   <= w_done_next;
         r_error  <= w_error_next;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and output decode
   // ------------------------------------------------------------------
   always_comb begin
      w_state_next  = r_state;
      w_idx_next    = r_idx;
      w_step_next   = r_step;
      w_min_next    = r_min;
      w_argmin_next = r_argmin;
      w_last_next   = r_last;
      w_done_next   = 1'b0;
      w_error_next  = 1'b0;

      bus.sym_ready = 1'b0;
      bus.acs_en    = 1'b0;
      bus.acs_idx   = '0;
      bus.sv_we     = 1'b0;
      bus.sv_addr   = '0;
      bus.norm_en   = 1'b0;
      bus.norm_val  = '0;
      bus.tb_start  = 1'b0;
      bus.tb_state  = '0;
      bus.tb_len    = '0;

      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_state_next = S_WAIT_SYM;
               w_step_next  = '0;
            end
         end

         S_WAIT_SYM: begin
            // Ready is withdrawn during abort so the FIFO never sees a
            // handshake for a symbol the sequencer is going to drop.
            bus.sym_ready = !i_abort;
            if (bus.sym_valid) begin
               w_last_next  = bus.sym_last;
               w_idx_next   = '0;
               w_min_next   = '1;
               w_state_next = S_ACS;
            end
         end

         S_ACS: begin
            bus.acs_en  = 1'b1;
            bus.sv_we   = 1'b1;
            bus.acs_idx = r_idx;
            bus.sv_addr = r_step[STW-1:0];
            // Strict compare: on equal metrics the earlier (lower) index is kept.
            if (bus.acs_metric < r_min) begin
               w_min_next    = bus.acs_metric;
               w_argmin_next = r_idx;
            end
            if (r_idx == LAST_IDX) begin
               w_state_next = S_NORM;
            end else begin
               w_idx_next = r_idx + SW'(1);
            end
         end

         S_NORM: begin
            bus.norm_en  = 1'b1;
            bus.norm_val = r_min;
            w_step_next  = r_step + (STW + 1)'(1);
            if (r_last) begin
               w_state_next = S_TB_REQ;
            end else if (r_step == STEP_LIMIT) begin
               // Survivor memory is full and the frame has not ended.
               w_error_next = 1'b1;
               w_state_next = S_IDLE;
            end else begin
               w_state_next = S_WAIT_SYM;
            end
         end

         S_TB_REQ: begin
            // Suppressed under abort: a cancelled frame never starts traceback.
            bus.tb_start = !i_abort;
            bus.tb_state = r_argmin;
            bus.tb_len   = r_step;
            w_state_next = S_TB_WAIT;
         end

         S_TB_WAIT: begin
            if (bus.tb_done) begin
               w_done_next  = 1'b1;
               w_state_next = S_IDLE;
            end
         end

         default: begin
            w_state_next = S_IDLE;
         end
      endcase

      // Abort overrides every transition above and freezes the datapath.
      if (i_abort) begin
         w_state_next  = S_IDLE;
         w_idx_next    = r_idx;
         w_step_next   = r_step;
         w_min_next    = r_min;
         w_argmin_next = r_argmin;
         w_last_next   = r_last;
         w_done_next   = 1'b0;
         w_error_next  = 1'b0;
      end
   end

   assign o_busy  = (r_state != S_IDLE);
   assign o_done  = r_done;
   assign o_error = r_error;

endmodule

// File: tb/tb_viterbi_acs_sequencer.sv
// ---------------------------------------------------------------------------
// tb_viterbi_acs_sequencer
//   Table-driven frames plus randomized frames checked against a behavioural
//   model (per-step minimum, first-index argmin, frame length), and
//   hand-written sequences for hold-off, abort and mid-frame reset.
// ---------------------------------------------------------------------------
module tb_viterbi_acs_sequencer;

   localparam int NS   = 11;
   localparam int SW   = 4;
   localparam int MW   = 8;
   localparam int MAXS = 64;
   localparam int STW  = 6;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic abort;
   logic busy;
   logic done;
   logic error;

   always #5 clk = ~clk;

   viterbi_acs_sequencer_if #(.SW(SW), .MW(MW), .STW(STW)) bus ();

   viterbi_acs_sequencer #(
      .NUM_STATES(NS), .SW(SW), .MW(MW), .MAX_STEPS(MAXS), .STW(STW)
   ) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_start (start),
      .i_abort (abort),
      .o_busy  (busy),
      .o_done  (done),
      .o_error (error),
      .bus     (bus)
   );

   // ACS unit stand-in: metric looked up by (step, state)
   logic [7:0] metric_tab [0:MAXS-1][0:NS-1];

   always_comb begin
      bus.acs_metric = 8'hEE;
      if (int'(bus.acs_idx) < NS) bus.acs_metric = metric_tab[bus.sv_addr][bus.acs_idx];
   end

   // ---------------- monitor (sole writer of these variables) ----------------
   logic [7:0] norm_hist [$];
   int         idx_seen [$];
   int         tb_n   = 0;
   int         done_n = 0;
   int         err_n  = 0;
   int         bad_n  = 0;
   int         mon_step = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (bus.sv_we !== bus.acs_en) bad_n++;
         if (!busy) begin
            mon_step = 0;
            idx_seen.delete();
         end
         if (bus.acs_en) begin
            if (int'(bus.sv_addr) != mon_step) bad_n++;
            idx_seen.push_back(int'(bus.acs_idx));
         end
         if (bus.norm_en) begin
            norm_hist.push_back(bus.norm_val);
            if (idx_seen.size() != NS) bad_n++;
            else for (int i = 0; i < NS; i++) if (idx_seen[i] != i) bad_n++;
            idx_seen.delete();
            mon_step++;
         end
         if (bus.tb_start) tb_n++;
         if (done)         done_n++;
         if (error)        err_n++;
      end
   end

   // ---------------- checking helpers ----------------
   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic longint outs_vec();
      return longint'({bus.sym_ready, bus.acs_en, bus.acs_idx, bus.sv_we, bus.sv_addr,
                       bus.norm_en, bus.norm_val, bus.tb_start, bus.tb_state, bus.tb_len,
                       busy, done, error});
   endfunction

   // ---------------- reference model ----------------
   int exp_norm [MAXS];
   int model_arg = 0;   // argmin persists across steps and frames (only reset clears it)

   task automatic fill(input int mode);
      int pat [4];
      pat = '{9, 3, 7, 3};
      for (int s = 0; s < MAXS; s++) begin
         for (int i = 0; i < NS; i++) begin
            case (mode)
               0:       metric_tab[s][i] = 8'(20 - i);
               1:       metric_tab[s][i] = 8'd5;
               2:       metric_tab[s][i] = (i < 4) ? 8'(pat[i]) : 8'd12;
               default: metric_tab[s][i] = 8'($urandom_range(0, 255));
            endcase
         end
      end
   endtask

   task automatic model(input int nsym, output int arg);
      int best;
      for (int s = 0; s < nsym; s++) begin
         best = 255;
         for (int i = 0; i < NS; i++) begin
            if (int'(metric_tab[s][i]) < best) begin
               best      = int'(metric_tab[s][i]);
               model_arg = i;
            end
         end
         exp_norm[s] = best;
      end
      arg = model_arg;
   endtask

   // ---------------- drivers ----------------
   task automatic send_sym(input bit last);
      int n;
      bus.sym_valid = 1'b1;
      bus.sym_last  = last;
      n = 0;
      while (!bus.sym_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.sym_ready) chk("sym_ready_timeout", bus.sym_ready, 1);
      @(negedge clk);
      bus.sym_valid = 1'b0;
      bus.sym_last  = 1'b0;
   endtask

   task automatic run_frame(input int nsym, input bit last, input int mode, input int hold,
                            input int tbdly, output int ob_state, output int ob_len,
                            output int ob_norm, output int ob_done, output int ob_err);
      int arg, nb, tb0, d0, e0, b0, n;
      fill(mode);
      model(nsym, arg);
      #2;
      nb = norm_hist.size(); tb0 = tb_n; d0 = done_n; e0 = err_n; b0 = bad_n;
      ob_state = -1;
      ob_len   = -1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_busy", busy, 1);
      for (int h = 0; h < hold; h++) begin
         chk("hold_ready_noacs_busy", {bus.sym_ready, bus.acs_en, busy}, 3'b101);
         @(negedge clk);
      end
      for (int k = 0; k < nsym; k++) send_sym(last && (k == nsym - 1));
      if (last) begin
         n = 0;
         while (!bus.tb_start && n < 40) begin
            @(negedge clk);
            n++;
         end
         chk("tb_start_seen", bus.tb_start, 1);
         ob_state = int'(bus.tb_state);
         ob_len   = int'(bus.tb_len);
         chk("tb_state_model", bus.tb_state, arg);
         @(negedge clk);
         repeat (tbdly) @(negedge clk);
         chk("no_done_before_tb_done", done, 0);
         bus.tb_done = 1'b1;
         @(negedge clk);
         bus.tb_done = 1'b0;
         chk("done_pulse_idle", {done, busy}, 2'b10);
         @(negedge clk);
         chk("done_width", done, 0);
      end else begin
         n = 0;
         while (!bus.norm_en && n < 40) begin
            @(negedge clk);
            n++;
         end
         chk("final_norm_seen", bus.norm_en, 1);
         @(negedge clk);
         chk("error_pulse_idle", {error, busy}, 2'b10);
         @(negedge clk);
         chk("error_width", error, 0);
      end
      #2;
      chk("norm_count", norm_hist.size() - nb, nsym);
      for (int s = 0; s < nsym; s++)
         if (nb + s < norm_hist.size()) chk("norm_val", norm_hist[nb + s], exp_norm[s]);
      ob_norm = (norm_hist.size() > nb) ? int'(norm_hist[norm_hist.size() - 1]) : -1;
      ob_done = done_n - d0;
      ob_err  = err_n - e0;
      chk("tb_start_count", tb_n - tb0, last ? 1 : 0);
      chk("acs_protocol", bad_n - b0, 0);
      chk("idle_after_frame", busy, 0);
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      int nsym; bit last; int mode;
      int e_state; int e_len; int e_norm; int e_done; int e_err;
   } vec_t;

   vec_t tab [5];

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int os, ol, on, od, oe, n, d0, e0, t0, nsym;

      tab[0] = '{3,  1'b1, 0, 10, 3,  10, 1, 0};   // metric 20-idx
      tab[1] = '{2,  1'b1, 1, 0,  2,  5,  1, 0};   // all equal -> lowest index
      tab[2] = '{1,  1'b1, 2, 1,  1,  3,  1, 0};   // {9,3,7,3,...} -> index 1
      tab[3] = '{64, 1'b0, 0, -1, -1, 10, 0, 1};   // overflow
      tab[4] = '{64, 1'b1, 0, 10, 64, 10, 1, 0};   // full legal frame

      rst = 1'b1; start = 1'b0; abort = 1'b0;
      bus.sym_valid = 1'b0; bus.sym_last = 1'b0; bus.tb_done = 1'b0;
      fill(0);
      repeat (3) @(negedge clk);
      chk("reset_outputs", outs_vec(), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_outputs", outs_vec(), 0);

      for (int v = 0; v < 5; v++) begin
         run_frame(tab[v].nsym, tab[v].last, tab[v].mode, 0, v % 3, os, ol, on, od, oe);
         chk($sformatf("vec%0d_tb_state", v), os, tab[v].e_state);
         chk($sformatf("vec%0d_tb_len", v),   ol, tab[v].e_len);
         chk($sformatf("vec%0d_norm", v),     on, tab[v].e_norm);
         chk($sformatf("vec%0d_done", v),     od, tab[v].e_done);
         chk($sformatf("vec%0d_error", v),    oe, tab[v].e_err);
         $display("vec %0d: nsym=%0d last=%0d tb_state=%0d tb_len=%0d norm=%0d done=%0d err=%0d",
                  v, tab[v].nsym, tab[v].last, os, ol, on, od, oe);
      end

      // sym_valid withheld for 10 cycles in WAIT_SYM
      run_frame(2, 1'b1, 0, 10, 1, os, ol, on, od, oe);
      chk("hold_tb_len", ol, 2);
      chk("hold_done", od, 1);
      $display("hold frame: tb_state=%0d tb_len=%0d done=%0d", os, ol, od);

      // abort during ACS at idx 4 (start asserted alongside is ignored)
      fill(0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      send_sym(1'b0);
      n = 0;
      while (!(bus.acs_en && bus.acs_idx == 4'd4) && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("abort_reach_idx4", bus.acs_idx, 4);
      #2;
      t0 = tb_n; d0 = done_n; e0 = err_n;
      abort = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("abort_idle_next", {busy, bus.acs_en, bus.norm_en}, 0);
      start = 1'b1;                       // abort wins over start in IDLE too
      @(negedge clk);
      abort = 1'b0; start = 1'b0;
      chk("abort_beats_start", busy, 0);
      repeat (4) @(negedge clk);
      #2;
      chk("abort_no_events", (tb_n - t0) + (done_n - d0) + (err_n - e0), 0);
      $display("abort: busy=%0d events=%0d", busy, (tb_n - t0) + (done_n - d0) + (err_n - e0));
      run_frame(2, 1'b1, 0, 0, 0, os, ol, on, od, oe);
      chk("after_abort_tb_len", ol, 2);
      chk("after_abort_done", od, 1);

      // reset in TB_WAIT with tb_done coincident
      fill(0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      send_sym(1'b1);
      n = 0;
      while (!bus.tb_start && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("rst_seq_tb_start", bus.tb_start, 1);
      @(negedge clk);
      #2;
      d0 = done_n;
      rst = 1'b1; bus.tb_done = 1'b1;
      @(negedge clk);
      bus.tb_done = 1'b0;
      chk("rst_outputs_zero", outs_vec(), 0);
      rst = 1'b0;
      model_arg = 0;
      @(negedge clk);
      chk("rst_no_done", done, 0);
      #2;
      chk("rst_no_done_count", done_n - d0, 0);
      $display("rst in TB_WAIT: busy=%0d done=%0d", busy, done);

      // randomized frames against the model
      for (int r = 0; r < 6; r++) begin
         nsym = int'($urandom_range(1, 5));
         run_frame(nsym, 1'b1, 3, 0, int'($urandom_range(0, 3)), os, ol, on, od, oe);
         chk("rand_tb_len", ol, nsym);
         chk("rand_done", od, 1);
         chk("rand_error", oe, 0);
         $display("rand %0d: nsym=%0d tb_state=%0d tb_len=%0d norm=%0d", r, nsym, os, ol, on);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
